// File: rtl/partition_eval_pkg.sv
// Shared types and width helpers for the partition evaluation blocks.
package partition_eval_pkg;

   // Sweep sequencer states.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StApply = 2'd1,
      StEmit  = 2'd2,
      StDone  = 2'd3
   } sweep_state_e;

   // Width of the Hamming-distance accumulator: holds 2^num_in * num_out without saturating.
   function automatic int unsigned err_bits_w(input int unsigned num_in,
                                              input int unsigned num_out);
      return num_in + $clog2(num_out) + 1;
   endfunction

   // Width needed to hold a popcount of n bits (0..n inclusive).
   function automatic int unsigned popcount_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational population count; fed with po ^ po_ref it yields the per-row Hamming distance.
module hamming_popcount
   import partition_eval_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]             bits,
   output logic [popcount_w(WIDTH)-1:0] count
);

   localparam int unsigned CntW = popcount_w(WIDTH);

   // Sum the set bits.
   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         count = count + CntW'(bits[i]);
      end
   end

endmodule

// File: rtl/partition_sweep_eval.sv
// Exhaustive truth-table sweeper: drives every input vector of a partition, samples the
// approximate and golden outputs after a settle window, streams {pi, po} rows over a
// valid/ready port and accumulates erroneous-row and Hamming-distance totals.
module partition_sweep_eval
   import partition_eval_pkg::*;
#(
   parameter int unsigned NUM_IN  = 7,
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned SETTLE  = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   output logic                                   busy,
   output logic                                   done,
   output logic [NUM_IN-1:0]                      pi,
   input  logic [NUM_OUT-1:0]                     po,
   input  logic [NUM_OUT-1:0]                     po_ref,
   output logic                                   row_valid,
   input  logic                                   row_ready,
   output logic [NUM_IN+NUM_OUT-1:0]              row_data,
   output logic [NUM_IN:0]                        err_rows,
   output logic [err_bits_w(NUM_IN, NUM_OUT)-1:0] err_bits
);

   localparam int unsigned ErrRowsW = NUM_IN + 1;
   localparam int unsigned ErrBitsW = err_bits_w(NUM_IN, NUM_OUT);
   localparam int unsigned PopW     = popcount_w(NUM_OUT);
   localparam int unsigned SettleW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned RowW     = NUM_IN + NUM_OUT;

   sweep_state_e         state_q, state_d;
   logic [NUM_IN-1:0]    idx_q;
   logic [SettleW-1:0]   settle_q;
   logic [RowW-1:0]      row_data_q;
   logic [ErrRowsW-1:0]  err_rows_q;
   logic [ErrBitsW-1:0]  err_bits_q;

   logic                 settle_last;
   logic                 idx_last;
   logic                 start_sweep;
   logic                 sample_row;
   logic                 advance;
   logic [NUM_OUT-1:0]   diff_bits;
   logic [PopW-1:0]      diff_cnt;

   assign diff_bits   = po ^ po_ref;
   assign settle_last = (settle_q == SettleW'(SETTLE - 1));
   assign idx_last    = &idx_q;

   hamming_popcount #(
      .WIDTH (NUM_OUT)
   ) u_popcount (
      .bits  (diff_bits),
      .count (diff_cnt)
   );

   // Next-state decode and the one-cycle strobes that steer the datapath.
   always_comb begin
      state_d     = state_q;
      start_sweep = 1'b0;
      sample_row  = 1'b0;
      advance     = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StApply;
               start_sweep = 1'b1;
            end
         end
         StApply: begin
            if (settle_last) begin
               state_d    = StEmit;
               sample_row = 1'b1;
            end
         end
         StEmit: begin
            if (row_ready) begin
               advance = 1'b1;
               // The terminal vector exits instead of wrapping, so each row appears once.
               state_d = idx_last ? StDone : StApply;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Vector index and settle counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         settle_q <= '0;
      end else begin
         if (start_sweep) begin
            idx_q    <= '0;
            settle_q <= '0;
         end else if (state_q == StApply) begin
            settle_q <= settle_last ? '0 : settle_q + SettleW'(1);
         end
         if (advance && !idx_last) begin
            idx_q <= idx_q + NUM_IN'(1);
         end
      end
   end

   // Row capture and error accumulation on the edge that leaves APPLY.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_data_q <= '0;
         err_rows_q <= '0;
         err_bits_q <= '0;
      end else if (start_sweep) begin
         err_rows_q <= '0;
         err_bits_q <= '0;
      end else if (sample_row) begin
         row_data_q <= {idx_q, po};
         err_bits_q <= err_bits_q + ErrBitsW'(diff_cnt);
         err_rows_q <= err_rows_q + ErrRowsW'(diff_cnt != '0);
      end
   end

   // Status and port outputs decoded from the state register.
   always_comb begin
      busy      = (state_q == StApply) || (state_q == StEmit);
      done      = (state_q == StDone);
      row_valid = (state_q == StEmit);
      pi        = ((state_q == StApply) || (state_q == StEmit)) ? idx_q : '0;
      row_data  = row_data_q;
      err_rows  = err_rows_q;
      err_bits  = err_bits_q;
   end

endmodule

// File: tb/tb_partition_sweep_eval.sv
// Scoreboard bench for partition_sweep_eval: a SETTLE=1 instance for the functional sweeps and a
// SETTLE=3 instance whose approximate outputs lag pi by two cycles to exercise the settle window.
module tb_partition_sweep_eval;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, row_ready;
   logic        busy, done, row_valid;
   logic [6:0]  pi;
   logic [3:0]  po, po_ref;
   logic [10:0] row_data;
   logic [7:0]  err_rows;
   logic [9:0]  err_bits;

   logic        start3;
   logic        row_ready3 = 1'b1;
   logic        busy3, done3, row_valid3;
   logic [6:0]  pi3, pi3_d1, pi3_d2;
   logic [3:0]  po3, po_ref3;
   logic [10:0] row_data3;
   logic [7:0]  err_rows3;
   logic [9:0]  err_bits3;

   int mode;
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_hs  = -1;

   logic [10:0] exp_q[$];
   logic [10:0] exp3_q[$];

   // Golden partition: 3-bit + 3-bit adder with carry-in.
   function automatic logic [3:0] gold(input logic [6:0] v);
      logic [3:0] a, b, c;
      a = {1'b0, v[2:0]};
      b = {1'b0, v[5:3]};
      c = {3'b000, v[6]};
      return a + b + c;
   endfunction

   // Error injected into the approximate outputs for each test mode.
   function automatic logic [3:0] mask(input int m, input logic [6:0] v);
      if (m == 1) return 4'b0001;
      if (m == 2 && v == 7'h55) return 4'b1111;
      return 4'b0000;
   endfunction

   always_comb begin
      po_ref = gold(pi);
      po     = gold(pi) ^ mask(mode, pi);
   end

   always @(posedge clk) begin
      pi3_d1 <= pi3;
      pi3_d2 <= pi3_d1;
      cyc    <= cyc + 1;
   end

   always_comb begin
      po_ref3 = gold(pi3);
      po3     = gold(pi3_d2);
   end

   partition_sweep_eval #(.NUM_IN(7), .NUM_OUT(4), .SETTLE(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pi        (pi),
      .po        (po),
      .po_ref    (po_ref),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_data  (row_data),
      .err_rows  (err_rows),
      .err_bits  (err_bits)
   );

   partition_sweep_eval #(.NUM_IN(7), .NUM_OUT(4), .SETTLE(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start3),
      .busy      (busy3),
      .done      (done3),
      .pi        (pi3),
      .po        (po3),
      .po_ref    (po_ref3),
      .row_valid (row_valid3),
      .row_ready (row_ready3),
      .row_data  (row_data3),
      .err_rows  (err_rows3),
      .err_bits  (err_bits3)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for the SETTLE=1 instance: pops one expected row per handshake.
   logic pend = 1'b0;
   always @(negedge clk) begin
      logic [10:0] e;
      if (rst_n && pend) chk("row_valid_held", row_valid, 1);
      if (rst_n && row_valid && row_ready) begin
         if (exp_q.size() == 0) begin
            chk("row_queue_nonempty", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("row_data", row_data, e);
         end
      end
      pend = rst_n && row_valid && !row_ready;
   end

   // Monitor for the SETTLE=3 instance: row contents and handshake spacing.
   always @(negedge clk) begin
      logic [10:0] e;
      if (rst_n && row_valid3 && row_ready3) begin
         if (exp3_q.size() == 0) begin
            chk("row_queue_nonempty_s3", exp3_q.size(), 1);
         end else begin
            e = exp3_q.pop_front();
            chk("row_data_s3", row_data3, e);
            if (last_hs >= 0) chk("row_spacing_s3", cyc - last_hs, 4);
            last_hs = cyc;
         end
      end
   end

   task automatic do_start(input int m);
      mode = m;
      for (int k = 0; k < 128; k++) begin
         exp_q.push_back({7'(k), gold(7'(k)) ^ mask(m, 7'(k))});
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("pi_after_start", pi, 0);
      chk("busy_after_start", busy, 1);
      chk("done_after_start", done, 0);
   endtask

   task automatic wait_done(input bit s3, output int n);
      n = 0;
      while (!(s3 ? done3 : done) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_pi(input logic [6:0] v, input bit need_valid);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(posedge clk); #1;
         if (pi == v && (!need_valid || row_valid)) hit = 1'b1;
      end
      chk("wait_pi_reached", hit, 1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0; row_ready = 1'b1; mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pi", pi, 0);
      chk("rst_row_valid", row_valid, 0);
      chk("rst_row_data", row_data, 0);
      chk("rst_err_rows", err_rows, 0);
      chk("rst_err_bits", err_bits, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_busy_s3", busy3, 0);
      rst_n = 1'b1;

      // Exact partition: no errors, done 256 edges after the start edge.
      do_start(0);
      wait_done(1'b0, n);
      chk("done_cycles", n, 256);
      chk("exact_err_rows", err_rows, 0);
      chk("exact_err_bits", err_bits, 0);
      chk("exact_rows_left", exp_q.size(), 0);
      chk("done_busy", busy, 0);
      chk("done_pi", pi, 0);

      // One flipped bit on every vector.
      do_start(1);
      wait_done(1'b0, n);
      chk("flip_err_rows", err_rows, 128);
      chk("flip_err_bits", err_bits, 128);
      chk("flip_rows_left", exp_q.size(), 0);

      // Fully inverted outputs only at 0x55; counters must restart from zero.
      do_start(2);
      wait_done(1'b0, n);
      chk("single_err_rows", err_rows, 1);
      chk("single_err_bits", err_bits, 4);
      chk("single_rows_left", exp_q.size(), 0);

      // Back-pressure on row 5, then a start pulse mid-sweep that must be ignored.
      do_start(1);
      wait_pi(7'd5, 1'b1);
      row_ready = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         chk("stall_valid", row_valid, 1);
         chk("stall_pi", pi, 5);
         chk("stall_row_data", row_data, {7'd5, gold(7'd5) ^ 4'b0001});
         chk("stall_err_rows", err_rows, 6);
         chk("stall_err_bits", err_bits, 6);
      end
      row_ready = 1'b1;
      wait_pi(7'd20, 1'b0);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("ignored_start_pi", pi, 20);
      chk("ignored_start_valid", row_valid, 1);
      wait_done(1'b0, n);
      chk("stall_final_err_rows", err_rows, 128);
      chk("stall_final_err_bits", err_bits, 128);
      chk("stall_rows_left", exp_q.size(), 0);

      // Reset while row 40 is being applied.
      do_start(1);
      wait_pi(7'd40, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_pi", pi, 0);
      chk("midrst_row_valid", row_valid, 0);
      chk("midrst_row_data", row_data, 0);
      chk("midrst_err_rows", err_rows, 0);
      chk("midrst_err_bits", err_bits, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rows_left", exp_q.size(), 88);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (5) begin
         @(posedge clk); #1;
         chk("post_rst_idle", row_valid, 0);
      end

      // Fresh sweep after reset starts at pi=0 with zeroed counters.
      do_start(1);
      wait_done(1'b0, n);
      chk("resweep_cycles", n, 256);
      chk("resweep_err_rows", err_rows, 128);
      chk("resweep_err_bits", err_bits, 128);
      chk("resweep_rows_left", exp_q.size(), 0);

      // SETTLE=3 instance: outputs valid only after the full settle window.
      for (int k = 0; k < 128; k++) exp3_q.push_back({7'(k), gold(7'(k))});
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      chk("s3_pi_after_start", pi3, 0);
      chk("s3_busy_after_start", busy3, 1);
      wait_done(1'b1, n);
      chk("s3_done_cycles", n, 512);
      chk("s3_err_rows", err_rows3, 0);
      chk("s3_err_bits", err_bits3, 0);
      chk("s3_rows_left", exp3_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/partition_sweep_eval.md
# partition_sweep_eval

Exhaustive truth-table sweeper for one partition of an approximate circuit. It counts through all 2^NUM_IN input vectors and drives them onto the partition's primary inputs. For each vector it samples the approximate outputs and the golden outputs, streams each row out over a valid/ready port, and accumulates error metrics. It sits directly upstream of the partition under evaluation and directly downstream of the golden model, and feeds the characterisation and error-metric logic.

## Interface
- NUM_IN, default 7: partition primary-input count; the sweep length is 2^NUM_IN.
- NUM_OUT, default 4: partition primary-output count.
- SETTLE, default 1, must be ≥1: cycles each vector is held before its outputs are sampled.

- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begins a sweep; honoured only in IDLE or DONE.
- busy  out  1  high in APPLY and EMIT.
- done  out  1  high in DONE; held until the next start or reset.
- pi  out  NUM_IN  vector driven to the partition and the golden model.
- po  in  NUM_OUT  approximate partition outputs.
- po_ref  in  NUM_OUT  golden outputs.
- row_valid  out  1  row_data is valid.
- row_ready  in  1  consumer accepts the row.
- row_data  out  NUM_IN+NUM_OUT  {pi, po} of the sampled row.
- err_rows  out  NUM_IN+1  count of rows where po≠po_ref.
- err_bits  out  NUM_IN+$clog2(NUM_OUT)+1  total Hamming distance across the sweep.

## Operation
- The FSM has four states:
  - IDLE: pi=0, no rows emitted.
  - APPLY: pi=idx; hold for SETTLE cycles.
  - EMIT: row_valid=1.
  - DONE: sweep complete.
- Transitions:
  - IDLE/DONE + start → APPLY. On this transition: idx=0, err_rows=0, err_bits=0, done=0.
  - APPLY, final settle cycle → EMIT. On the clock edge leaving APPLY:
    - register row_data={idx, po};
    - d = popcount(po ^ po_ref);
    - err_bits += d;
    - err_rows += (d≠0).
  - EMIT + row_ready → APPLY with idx+1, or → DONE if idx = 2^NUM_IN−1.
  - EMIT without row_ready: hold. row_data, pi, idx and the counters stay stable.
- start in APPLY or EMIT is ignored.
- idx never wraps. The terminal vector exits to DONE, so each vector is emitted exactly once per sweep.
- The counters are sized to never saturate: the maxima are 2^NUM_IN and 2^NUM_IN·NUM_OUT.
- err_rows and err_bits stay readable in DONE until the next start.

## Timing
- Reset values: pi=0, row_valid=0, row_data=0, err_rows=0, err_bits=0, busy=0, done=0, state=IDLE.
- Reset takes effect at the first rising edge with rst_n=0, in any state, including mid-sweep. No row is emitted afterwards.
- start sampled at edge t → pi=0 and busy=1 from t+1.
- Per row with row_ready held high: SETTLE+1 cycles.
- Full sweep: 2^NUM_IN·(SETTLE+1) cycles from start to done. For the defaults that is 256.
- po and po_ref are sampled SETTLE cycles after pi changes. The partition path must settle within that window.
- done asserts the cycle after the last handshake.
- The row is accepted on any edge where row_valid and row_ready are both high. row_valid is independent of row_ready, and row_valid never drops without a handshake.

## Structure
- Shared package partition_eval_pkg holds:
  - the state enum (IDLE, APPLY, EMIT, DONE);
  - a width function for the counters, err_bits_w(NUM_IN, NUM_OUT), reused by the downstream metric blocks.
- One sub-module, hamming_popcount: combinational popcount of NUM_OUT bits.
- The settle counter, idx register, FSM and accumulators live in the top level.

## Test plan
- Defaults, po=po_ref (exact adder), row_ready=1 → 128 rows, with row_data[10:4] = 0..127 in order; err_rows=0, err_bits=0; done at cycle 256 after start.
- po=po_ref^4'b0001 for all vectors → err_rows=128, err_bits=128.
- po=~po_ref only at pi=7'h55 → err_rows=1, err_bits=4; the row_data for idx 0x55 carries the inverted po.
- row_ready low for 10 cycles while row 5 is pending → row_valid stays high; row_data, pi=5 and the counters are stable; no duplicate or skipped rows.
- start pulsed mid-sweep → ignored. rst_n low at row 40 → all outputs zero next cycle. A new start sweeps again from pi=0 with zeroed counters.
- SETTLE=3 → row spacing 4 cycles; done at cycle 512; po is sampled 3 cycles after each pi change.
